mix_cols_iter: RTL and testbench

//  Iterative, parametrised MixColumns engine for the AES-128 datapath.
//  - Takes a full 128-bit state over a valid/ready handshake.
//  - Transforms LANES columns per clock, then holds the result until the consumer takes it.
//  - Optional decrypt (InvMixColumns) mode.
//  - Sits between ShiftRows and AddRoundKey in the round pipeline.

---
 rtl/mix_cols_iter_if.sv | 23 ++
 rtl/mix_cols_iter.sv | 171 +++++++++++++++++
 tb/tb_mix_cols_iter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mix_cols_iter_if.sv
// Handshake bundle for mix_cols_iter: a state in from ShiftRows, a transformed state out to AddRoundKey.
interface mix_cols_iter_if;
  localparam int unsigned STATE_W = 128;

  logic               in_valid_i;
  logic               in_ready_o;
  logic [STATE_W-1:0] state_i;
  logic               mode_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [STATE_W-1:0] state_o;
  logic               busy_o;

  modport slave (
    input  in_valid_i, state_i, mode_i, out_ready_i,
    output in_ready_o, out_valid_o, state_o, busy_o
  );

  modport master (
    output in_valid_i, state_i, mode_i, out_ready_i,
    input  in_ready_o, out_valid_o, state_o, busy_o
  );
endinterface

// File: rtl/mix_cols_iter.sv
// Iterative AES-128 MixColumns engine transforming LANES columns per clock.
// Define MIX_COLS_INV_EN to build the InvMixColumns network and honour mode_i per block.
module mix_cols_iter #(
  parameter int unsigned LANES = 4
) (
  input  logic           clk,
  input  logic           rst,
  mix_cols_iter_if.slave bus
);
  localparam int unsigned NCOL    = 4;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned STATE_W = NCOL * COL_W;
  localparam int unsigned CNT_W   = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_lanes_chk
    $error("mix_cols_iter: LANES must be 1, 2 or 4");
  end

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic               rdy_q, rdy_d;
  logic               vld_q, vld_d;
  logic               busy_q, busy_d;
  logic [STATE_W-1:0] work_upd;
  logic [COL_W-1:0]   cols_upd [NCOL];
  logic [CNT_W-1:0]   col_idx;

`ifdef MIX_COLS_INV_EN
  logic mode_q, mode_d;
`else
  logic unused_mode;
  assign unused_mode = bus.mode_i;
`endif

  // Multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [COL_W-1:0] mix_fwd(input logic [COL_W-1:0] c);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = c;
    return {xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3,
            b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3,
            xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3)};
  endfunction

`ifdef MIX_COLS_INV_EN
  // 09/0B/0D/0E products share the x2/x4/x8 chain of each byte.
  function automatic logic [COL_W-1:0] mix_inv(input logic [COL_W-1:0] c);
    logic [7:0] b  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [COL_W-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      b[i]  = c[31-8*i -: 8];
      x2[i] = xt(b[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
      m9[i] = x8[i] ^ b[i];
      mb[i] = x8[i] ^ x2[i] ^ b[i];
      md[i] = x8[i] ^ x4[i] ^ b[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    for (int i = 0; i < 4; i++) begin
      r[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    end
    return r;
  endfunction
`endif

  // Transform the LANES columns starting at cnt_q; other columns pass through.
  always_comb begin
    col_idx  = cnt_q;
    work_upd = '0;
    for (int unsigned c = 0; c < NCOL; c++) begin
      cols_upd[c] = work_q[STATE_W-1-COL_W*c -: COL_W];
    end
    for (int unsigned l = 0; l < LANES; l++) begin
      col_idx = cnt_q + CNT_W'(l);
`ifdef MIX_COLS_INV_EN
      cols_upd[col_idx] = mode_q ? mix_inv(cols_upd[col_idx]) : mix_fwd(cols_upd[col_idx]);
`else
      cols_upd[col_idx] = mix_fwd(cols_upd[col_idx]);
`endif
    end
    for (int unsigned c = 0; c < NCOL; c++) begin
      work_upd[STATE_W-1-COL_W*c -: COL_W] = cols_upd[c];
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
`ifdef MIX_COLS_INV_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          work_d  = bus.state_i;
          cnt_d   = '0;
          state_d = BUSY;
`ifdef MIX_COLS_INV_EN
          mode_d  = bus.mode_i;
`endif
        end
      end
      BUSY: begin
        work_d = work_upd;
        cnt_d  = cnt_q + CNT_W'(LANES);
        if (({1'b0, cnt_q} + 3'(LANES)) == 3'd4) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d  = (state_d == IDLE);
    vld_d  = (state_d == DONE);
    busy_d = (state_d == BUSY) || (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MIX_COLS_INV_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
`ifdef MIX_COLS_INV_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign bus.in_ready_o  = rdy_q;
  assign bus.out_valid_o = vld_q;
  assign bus.busy_o      = busy_q;
  assign bus.state_o     = work_q;

endmodule

// File: tb/tb_mix_cols_iter.sv
// Randomised self-checking bench for mix_cols_iter against a GF(2^8) matrix-product reference model.
module tb_mix_cols_iter;
  localparam int unsigned LANES = 4;
  localparam int N = 4 / LANES;
`ifdef MIX_COLS_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  mix_cols_iter_if bus ();

  mix_cols_iter #(.LANES(LANES)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? (8'(aa << 1) ^ 8'h1b) : 8'(aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // r_i = sum_j m[(j-i) mod 4] * b_j with the first matrix row as m.
  function automatic logic [127:0] ref_state(input logic [127:0] s, input logic md);
    logic [7:0]   m [4];
    logic [7:0]   b [4];
    logic [7:0]   r;
    logic [127:0] o;
    if (INV_EN && md) begin
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) b[j] = s[127-32*c-8*j -: 8];
      for (int i = 0; i < 4; i++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++) r ^= gmul(m[(j-i+4)%4], b[j]);
        o[127-32*c-8*i -: 8] = r;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full transaction from IDLE: accept, measure latency, optional stall, release.
  task automatic run_block(input logic [127:0] din, input logic md, input int stall,
                           output logic [127:0] got);
    logic [127:0] exp;
    int lat;
    int bad;
    exp = ref_state(din, md);
    check("pre_ready", 128'(bus.in_ready_o), 128'd1);
    bus.state_i = din; bus.mode_i = md; bus.in_valid_i = 1'b1;
    bus.out_ready_i = (stall == 0);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0; bus.state_i = rnd128(); bus.mode_i = ~md;
    lat = 1; bad = 0;
    while (!bus.out_valid_o && lat < 20) begin
      if (bus.in_ready_o || !bus.busy_o) bad++;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 128'(lat), 128'(N + 1));
    got = bus.state_o;
    check("data", bus.state_o, exp);
    for (int s = 0; s < stall; s++) begin
      if (bus.in_ready_o || !bus.busy_o || !bus.out_valid_o || bus.state_o !== exp) bad++;
      bus.in_valid_i = s[0];
      bus.state_i = rnd128();
      @(posedge clk); #1;
    end
    bus.out_ready_i = 1'b1;
    bus.in_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    check("post_valid", 128'(bus.out_valid_o), 128'd0);
    check("post_idle", 128'({bus.in_ready_o, bus.busy_o}), 128'b10);
    check("window", 128'(bad), 128'd0);
  endtask

  initial begin
    logic [127:0] got;
    logic [127:0] blk [3];
    logic         bmd [3];
    int           acc_t [3];
    int           idx;
    int           ndone;
    int           cnt;

    rst = 1'b1;
    bus.in_valid_i = 1'b0; bus.state_i = '0; bus.mode_i = 1'b0; bus.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", 128'(bus.in_ready_o), 128'd1);
    check("rst_valid", 128'(bus.out_valid_o), 128'd0);
    check("rst_busy",  128'(bus.busy_o), 128'd0);
    check("rst_state", bus.state_o, 128'd0);

    run_block(128'hdb135345_f20a225c_01010101_2d26314c, 1'b0, 0, got);
    check("vec_fwd", got, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);

    run_block(128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b1, 0, got);
    check("vec_inv", got, INV_EN ? 128'hdb135345_f20a225c_01010101_2d26314c
                                 : ref_state(128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b0));

    run_block(rnd128(), 1'b0, 10, got);

    // Asynchronous reset mid-BUSY discards the block.
    bus.state_i = rnd128(); bus.in_valid_i = 1'b1; bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (N / 2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 128'(bus.out_valid_o), 128'd0);
    check("arst_busy",  128'(bus.busy_o), 128'd0);
    check("arst_state", bus.state_o, 128'd0);
    @(posedge clk); #1 rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid_o || bus.busy_o) cnt++;
    end
    check("arst_quiet", 128'(cnt), 128'd0);
    bus.out_ready_i = 1'b0;
    run_block(128'hd4d4d4d5_c6c6c6c6_01010101_2d26314c, 1'b0, 0, got);
    check("vec_after_rst", got, 128'hd5d5d7d6_c6c6c6c6_01010101_4d7ebdf8);

    for (int k = 0; k < 12; k++) begin
      run_block(rnd128(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), got);
    end

    // Back-to-back: in_valid held high across three blocks.
    for (int k = 0; k < 3; k++) begin
      blk[k] = rnd128();
      bmd[k] = 1'($urandom_range(0, 1));
      acc_t[k] = 0;
    end
    idx = 0; ndone = 0;
    bus.in_valid_i = 1'b1; bus.state_i = blk[0]; bus.mode_i = bmd[0]; bus.out_ready_i = 1'b1;
    for (int t = 0; t < 100 && ndone < 3; t++) begin
      if (bus.in_valid_i && bus.in_ready_o && idx < 3) begin
        acc_t[idx] = t;
        idx++;
      end
      if (bus.out_valid_o) begin
        check("b2b_data", bus.state_o, ref_state(blk[ndone], bmd[ndone]));
        ndone++;
      end
      @(posedge clk); #1;
      if (idx < 3) begin
        bus.state_i = blk[idx]; bus.mode_i = bmd[idx];
      end else begin
        bus.in_valid_i = 1'b0;
      end
    end
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    check("b2b_count", 128'(ndone), 128'd3);
    check("b2b_ii01", 128'(acc_t[1] - acc_t[0]), 128'(N + 2));
    check("b2b_ii12", 128'(acc_t[2] - acc_t[1]), 128'(N + 2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
